// File: rtl/tx_word.sv
// tx_word: streams a parallel word as consecutive 8N1 frames, low byte first.
// Optional header frame carrying SYNC_BYTE when TX_WORD_SYNC_EN is defined.
module tx_word #(
  parameter int          RESOLUTION = 12,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  TX,
  input  logic [RESOLUTION-1:0] data,
  input  logic                  baud_pulse,
  input  logic                  enable,
  output logic                  busy,
  output logic                  word_done
);

  localparam int NBYTES = (RESOLUTION + 7) / 8;
  localparam int W      = NBYTES * 8;
`ifdef TX_WORD_SYNC_EN
  localparam int NFR    = NBYTES + 1;
`else
  localparam int NFR    = NBYTES;
`endif
  localparam int IW     = $clog2(NFR + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  buf_q, buf_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_q, bit_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  pad;

  always_comb begin
    pad = '0;
    pad[RESOLUTION-1:0] = data;
  end

  // buf holds the bytes not yet loaded into the bit shifter
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (baud_pulse) begin
      unique case (state_q)
        IDLE: begin
          tx_d = 1'b1;
          if (enable) begin
`ifdef TX_WORD_SYNC_EN
            buf_d = pad;
            sh_d  = SYNC_BYTE;
`else
            buf_d = pad >> 8;
            sh_d  = pad[7:0];
`endif
            idx_d   = '0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            state_d = START;
          end
        end
        START: begin
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
          bit_d   = 3'd0;
          state_d = DATA;
        end
        DATA: begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
            bit_d = bit_q + 3'd1;
          end
        end
        STOP: begin
          if (idx_q == IW'(NFR - 1)) begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            sh_d    = buf_q[7:0];
            buf_d   = buf_q >> 8;
            tx_d    = 1'b0;
            state_d = START;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TX        = tx_q;
  assign busy      = busy_q;
  assign word_done = done_q;

endmodule

// File: tb/tb_tx_word.sv
// tb_tx_word: directed and random words checked against a frame-level model.
// Model builds the expected line bit sequence from the byte/frame rules.
module tb_tx_word;

  localparam int RES = 12;
  localparam int NB  = (RES + 7) / 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           TX;
  logic [RES-1:0] data = '0;
  logic           baud_pulse = 1'b0;
  logic           enable = 1'b0;
  logic           busy;
  logic           word_done;

  int nvec = 0;
  int nerr = 0;
  bit exp_q[$];

  tx_word #(.RESOLUTION(RES), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk),
    .reset(reset),
    .TX(TX),
    .data(data),
    .baud_pulse(baud_pulse),
    .enable(enable),
    .busy(busy),
    .word_done(word_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic baud();
    repeat (2) @(negedge clk);
    baud_pulse = 1'b1;
    @(negedge clk);
    baud_pulse = 1'b0;
  endtask

  task automatic push_frame(input int unsigned b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(((b >> i) & 1) != 0);
    exp_q.push_back(1'b1);
  endtask

  task automatic build(input int unsigned d);
    int unsigned v;
    v = d & ((1 << RES) - 1);
    exp_q.delete();
`ifdef TX_WORD_SYNC_EN
    push_frame(32'hA5);
`endif
    for (int k = 0; k < NB; k++) push_frame((v >> (8 * k)) & 255);
  endtask

  task automatic run_word(input logic [RES-1:0] d, input bit keep,
                          input bit chg, input logic [RES-1:0] nd);
    data   = d;
    enable = 1'b1;
    build(32'(d));
    for (int i = 0; i < exp_q.size(); i++) begin
      baud();
      if (i == 0) begin
        if (!keep) enable = 1'b0;
        if (chg) data = nd;
      end
      chk("tx_bit", TX, exp_q[i]);
      chk("busy_hi", busy, 1'b1);
      chk("done_lo", word_done, 1'b0);
    end
    baud();
    chk("tx_end", TX, 1'b1);
    chk("busy_end", busy, 1'b0);
    chk("done_pulse", word_done, 1'b1);
    @(negedge clk);
    chk("done_clr", word_done, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", TX, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", word_done, 1'b0);
    reset = 1'b0;
    baud();
    chk("idle_tx", TX, 1'b1);
    chk("idle_busy", busy, 1'b0);

    run_word(12'hABC, 1'b0, 1'b1, 12'h123);
    repeat (2) begin
      baud();
      chk("idle_gap", TX, 1'b1);
    end
    run_word(12'h123, 1'b0, 1'b0, '0);

    run_word(12'h5A7, 1'b1, 1'b0, '0);
    run_word(12'hFFF, 1'b1, 1'b0, '0);
    run_word(12'h000, 1'b0, 1'b0, '0);
    repeat (15) begin
      baud();
      chk("stay_idle_tx", TX, 1'b1);
      chk("stay_idle_busy", busy, 1'b0);
    end

    for (int n = 0; n < 8; n++) begin
      run_word(RES'($urandom), 1'($urandom), 1'($urandom), RES'($urandom));
    end
    enable = 1'b0;
    baud();

    data   = 12'h0F0;
    enable = 1'b1;
    baud();
    chk("pre_rst_start", TX, 1'b0);
    repeat (3) baud();
    reset = 1'b1;
    #1;
    chk("async_rst_tx", TX, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) begin
      baud();
      chk("post_rst_tx", TX, 1'b1);
      chk("post_rst_busy", busy, 1'b0);
    end
    run_word(12'hC3D, 1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
